// File: rtl/qif_pkg.sv
// Shared constants and the saturation helper for the 8-bit QIF neuron datapath.
package qif_pkg;

  localparam int W_DEF   = 8;
  localparam int SAT_MAX = (1 << (W_DEF - 1)) - 1;
  localparam int SAT_MIN = -(1 << (W_DEF - 1));

  // Clamp a wide signed value into the signed range of a w-bit word.
  // The result is still returned 32 bits wide; the caller truncates to w bits.
  // 'clamped' reports whether the value had to be limited.
  function automatic logic signed [31:0] sat_w(input logic signed [31:0] x,
                                               input int w,
                                               output logic clamped);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi      = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo      = -hi - 32'sd1;
    clamped = 1'b0;
    sat_w   = x;
    if (x > hi) begin
      sat_w   = hi;
      clamped = 1'b1;
    end else if (x < lo) begin
      sat_w   = lo;
      clamped = 1'b1;
    end
  endfunction

endpackage

// File: rtl/syn_weight_rf.sv
// Synaptic weight register file: one write port, every weight visible in parallel
// on a flat bus so the adder can consume all channels in the same cycle.
module syn_weight_rf
  import qif_pkg::*;
#(
  parameter int N_SYN = 4,
  parameter int W     = W_DEF,
  parameter int AW    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [W-1:0]       data,
  output logic [N_SYN*W-1:0] w_flat
);

  logic [W-1:0] w_q [N_SYN];

  // Each entry decodes its own address, so indices >= N_SYN match no entry and are dropped.
  for (genvar gi = 0; gi < N_SYN; gi++) begin : g_entry
    // Per-entry weight register with synchronous clear.
    always_ff @(posedge clk) begin
      if (rst_n) begin
        w_q[gi] <= '0;
      end else if (we && (addr == AW'(gi))) begin
        w_q[gi] <= data;
      end
    end

    assign w_flat[gi*W +: W] = w_q[gi];
  end

endmodule

// File: rtl/syn_current_8b.sv
// Synapse stage: buffers presynaptic spikes between ticks, sums the weights of the
// channels that fired, and integrates them into a leaky, saturating synaptic current.
module syn_current_8b
  import qif_pkg::*;
#(
  parameter int N_SYN       = 4,
  parameter int W           = W_DEF,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,     // active-high synchronous reset
  input  logic                       tick,
  input  logic [N_SYN-1:0]           spike_in,
  input  logic                       w_we,
  input  logic [$clog2(N_SYN)-1:0]   w_addr,
  input  logic [W-1:0]               w_data,
  output logic signed [W-1:0]        I_syn,
  output logic                       I_valid,
  output logic                       sat_flag
);

  localparam int AW = $clog2(N_SYN);
  // Wide enough for current plus N_SYN full-scale weights without overflow.
  localparam int SW = W + AW + 1;

  logic [N_SYN-1:0]     pending_q;
  logic signed [W-1:0]  i_syn_q;
  logic signed [W-1:0]  i_syn_d;
  logic                 valid_q;
  logic                 sat_q;
  logic                 clamp_d;

  logic [N_SYN*W-1:0]   w_flat;
  logic [N_SYN-1:0]     sel;
  logic signed [SW-1:0] term [N_SYN];
  logic signed [SW-1:0] sum_d;
  logic signed [W-1:0]  leak;
  logic signed [SW-1:0] next_wide;

  syn_weight_rf #(
    .N_SYN (N_SYN),
    .W     (W),
    .AW    (AW)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (w_we),
    .addr   (w_addr),
    .data   (w_data),
    .w_flat (w_flat)
  );

  // A spike arriving in the tick cycle itself is counted in that tick.
  assign sel = pending_q | spike_in;

  // Weight register file updates at the same edge, so this tick sees the old weights.
  for (genvar gi = 0; gi < N_SYN; gi++) begin : g_term
    assign term[gi] = sel[gi] ? SW'($signed(w_flat[gi*W +: W])) : '0;
  end

  // Sum of selected weights, leak, and saturation of the new current.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N_SYN; k++) begin
      sum_d = sum_d + term[k];
    end
    leak      = i_syn_q >>> DECAY_SHIFT;
    next_wide = SW'(i_syn_q) - SW'(leak) + sum_d;
    clamp_d   = 1'b0;
    i_syn_d   = W'(sat_w(32'(next_wide), W, clamp_d));
  end

  // Spike buffering, current integration on tick, and the sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pending_q <= '0;
      i_syn_q   <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
    end else if (tick) begin
      pending_q <= '0;
      i_syn_q   <= i_syn_d;
      valid_q   <= 1'b1;
      if (clamp_d) begin
        sat_q <= 1'b1;
      end
    end else begin
      pending_q <= pending_q | spike_in;
      valid_q   <= 1'b0;
    end
  end

  assign I_syn    = i_syn_q;
  assign I_valid  = valid_q;
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_syn_current_8b.sv
// Bench for syn_current_8b: integer reference model checked every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_syn_current_8b;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tick;
  logic [3:0]        spike_in;
  logic              w_we;
  logic [1:0]        w_addr;
  logic [7:0]        w_data;
  logic signed [7:0] I_syn;
  logic              I_valid;
  logic              sat_flag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  syn_current_8b #(.N_SYN(4), .W(8), .DECAY_SHIFT(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .spike_in (spike_in),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .I_syn    (I_syn),
    .I_valid  (I_valid),
    .sat_flag (sat_flag)
  );

  // ---------------- reference model (plain integer arithmetic) ----------------
  int m_w [4];
  bit m_pend [4];
  int m_cur   = 0;
  bit m_valid = 0;
  bit m_sat   = 0;
  bit m_ok    = 0;

  function automatic int floor_div8(input int x);
    int r;
    r = ((x % 8) + 8) % 8;
    return (x - r) / 8;
  endfunction

  always @(posedge clk) begin
    int sum;
    int nxt;
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_w[k]    = 0;
        m_pend[k] = 0;
      end
      m_cur   = 0;
      m_valid = 0;
      m_sat   = 0;
      m_ok    = 1;
    end else begin
      if (tick) begin
        sum = 0;
        for (int k = 0; k < 4; k++)
          if (m_pend[k] || spike_in[k]) sum += m_w[k];
        nxt = m_cur - floor_div8(m_cur) + sum;
        if (nxt > 127)  begin nxt = 127;  m_sat = 1; end
        if (nxt < -128) begin nxt = -128; m_sat = 1; end
        m_cur   = nxt;
        m_valid = 1;
        for (int k = 0; k < 4; k++) m_pend[k] = 0;
      end else begin
        m_valid = 0;
        for (int k = 0; k < 4; k++) if (spike_in[k]) m_pend[k] = 1;
      end
      if (w_we) m_w[w_addr] = $signed(w_data);
    end
  end

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_ok) begin
      tests++;
      if (int'(I_syn) != m_cur) begin
        fails++;
        $display("FAIL model_I_syn t=%0t: got %0d expected %0d", $time, I_syn, m_cur);
      end
      tests++;
      if (I_valid != m_valid) begin
        fails++;
        $display("FAIL model_I_valid t=%0t: got %0b expected %0b", $time, I_valid, m_valid);
      end
      tests++;
      if (sat_flag != m_sat) begin
        fails++;
        $display("FAIL model_sat_flag t=%0t: got %0b expected %0b", $time, sat_flag, m_sat);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  task automatic idle_inputs();
    tick = 0; spike_in = '0; w_we = 0; w_addr = '0; w_data = '0;
  endtask

  // One cycle of stimulus, then return just after the edge that consumed it.
  task automatic cyc(input bit t, input logic [3:0] sp, input bit we,
                     input logic [1:0] a, input int d);
    tick = t; spike_in = sp; w_we = we; w_addr = a; w_data = 8'(d);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1;
    repeat (n) begin @(posedge clk); #1; end
    rst_n = 0;
  endtask

  task automatic wr(input logic [1:0] a, input int d);
    cyc(0, 4'b0000, 1, a, d);
  endtask

  int neg_exp [8] = '{-7, -6, -5, -4, -3, -2, -1, 0};

  initial begin
    rst_n = 1;
    // 1: reset held 3 cycles with every control input active
    tick = 1; spike_in = 4'b1111; w_we = 1; w_addr = 2'd0; w_data = 8'd55;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 0;
    idle_inputs();
    check("reset_I_syn", I_syn, 0);
    check("reset_I_valid", I_valid, 0);
    check("reset_sat_flag", sat_flag, 0);
    // weight write during reset must have been discarded
    cyc(1, 4'b0001, 0, 0, 0);
    check("reset_weight_cleared", I_syn, 0);

    // 2: single spike (twice on one channel, counted once), then pure decay
    do_reset(1);
    wr(0, 20);
    cyc(0, 4'b0001, 0, 0, 0);
    cyc(0, 4'b0001, 0, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0);
    cyc(1, 4'b0000, 0, 0, 0);
    check("spike_I_syn", I_syn, 20);
    check("spike_I_valid", I_valid, 1);
    cyc(1, 4'b0000, 0, 0, 0); check("decay1", I_syn, 18);
    cyc(1, 4'b0000, 0, 0, 0); check("decay2", I_syn, 16);
    cyc(1, 4'b0000, 0, 0, 0); check("decay3", I_syn, 14);
    cyc(1, 4'b0000, 0, 0, 0); check("decay4", I_syn, 13);
    cyc(0, 4'b0000, 0, 0, 0); check("valid_drops", I_valid, 0);

    // 3: same-cycle spike + tick + weight write uses old weight
    do_reset(1);
    wr(1, 10);
    cyc(1, 4'b0010, 1, 1, 50);
    check("same_cycle_old_weight", I_syn, 10);
    cyc(1, 4'b0010, 0, 0, 0);
    check("new_weight", I_syn, 59);
    cyc(1, 4'b0000, 0, 0, 0);
    check("spike_not_reheld", I_syn, 52);

    // 4: saturation both directions, sticky flag
    do_reset(1);
    for (int k = 0; k < 4; k++) wr(2'(k), 100);
    cyc(1, 4'b1111, 0, 0, 0);
    check("sat_pos_I_syn", I_syn, 127);
    check("sat_pos_flag", sat_flag, 1);
    for (int k = 0; k < 4; k++) wr(2'(k), -100);
    cyc(1, 4'b1111, 0, 0, 0);
    check("sat_neg_I_syn", I_syn, -128);
    check("sat_neg_flag", sat_flag, 1);

    // 5: negative leak with back-to-back ticks
    do_reset(1);
    check("sat_cleared_by_reset", sat_flag, 0);
    wr(0, -8);
    cyc(1, 4'b0001, 0, 0, 0);
    check("neg_start", I_syn, -8);
    tick = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 7) tick = 0;
      check($sformatf("neg_decay%0d", i), I_syn, neg_exp[i]);
      check($sformatf("neg_valid%0d", i), I_valid, 1);
    end
    cyc(1, 4'b0000, 0, 0, 0);
    check("zero_stays", I_syn, 0);

    // 6: reset mid-accumulation discards pending spikes, current and weights
    do_reset(1);
    wr(0, 40);
    cyc(1, 4'b0001, 0, 0, 0);
    check("pre_reset_I_syn", I_syn, 40);
    wr(1, 5);
    wr(3, 7);
    cyc(0, 4'b1011, 0, 0, 0);
    do_reset(1);
    cyc(1, 4'b0000, 0, 0, 0);
    check("post_reset_tick", I_syn, 0);
    cyc(1, 4'b1111, 0, 0, 0);
    check("post_reset_weights", I_syn, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
